// File: rtl/led_seq_pkg.sv
// Shared types and width helpers for the per-port link LED sequencer.
// Imported by led_port_fsm and led_port_sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_DOWN,
        ST_SYNC,
        ST_UP,
        ST_FLAP
    } port_state_t;

    localparam int unsigned DEF_PORTS       = 4;
    localparam int unsigned DEF_HOLD_OFF    = 1000;
    localparam int unsigned DEF_COOLOFF     = 10000;
    localparam int unsigned DEF_MAX_STRIKES = 3;
    localparam int unsigned DEF_SLOW_DIV    = 5000;
    localparam int unsigned DEF_FAST_DIV    = 1000;
    localparam int unsigned DEF_ACT_STRETCH = 500;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/led_port_fsm.sv
// One port: link FSM with flap tracker, hold/activity counters and LED register.
// Activity flicker in UP is built only when LED_ACTIVITY_EN is defined.
module led_port_fsm
    import led_seq_pkg::*;
#(
    parameter int unsigned HoldOff    = DEF_HOLD_OFF,
    parameter int unsigned Cooloff    = DEF_COOLOFF,
    parameter int unsigned MaxStrikes = DEF_MAX_STRIKES,
    parameter int unsigned ActStretch = DEF_ACT_STRETCH
) (
    input  logic clk,
    input  logic reset,
    input  logic link_r,
    input  logic tog_r,
    input  logic act_r,
    input  logic slow_phase,
    input  logic fast_phase,
    output logic led,
    output logic flapping
);

    localparam int unsigned HW = cnt_w(HoldOff);
    localparam int unsigned WW = cnt_w(Cooloff);
    localparam int unsigned SW = cnt_w(MaxStrikes);

    localparam logic [HW-1:0] HOLD_LD  = HW'(HoldOff);
    localparam logic [WW-1:0] WIN_LD   = WW'(Cooloff);
    localparam logic [SW-1:0] STRK_MAX = SW'(MaxStrikes);

    port_state_t   state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [WW-1:0] win_cnt_q, win_cnt_d;
    logic [SW-1:0] strikes_q, strikes_d;
    logic          led_q, led_d;
    logic          flapping_q, flapping_d;
    logic          flap_hit;

`ifdef LED_ACTIVITY_EN
    localparam int unsigned AW = cnt_w(2 * ActStretch - 1);
    localparam logic [AW-1:0] ACT_LD   = AW'(2 * ActStretch - 1);
    localparam logic [AW-1:0] ACT_HALF = AW'(ActStretch);

    logic [AW-1:0] act_cnt_q, act_cnt_d;
`else
    logic unused_act;
    assign unused_act = act_r ^ (ActStretch == 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_DOWN;
            hold_cnt_q <= '0;
            win_cnt_q  <= '0;
            strikes_q  <= '0;
            led_q      <= 1'b0;
            flapping_q <= 1'b0;
`ifdef LED_ACTIVITY_EN
            act_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            win_cnt_q  <= win_cnt_d;
            strikes_q  <= strikes_d;
            led_q      <= led_d;
            flapping_q <= flapping_d;
`ifdef LED_ACTIVITY_EN
            act_cnt_q  <= act_cnt_d;
`endif
        end
    end

    always_comb begin
        win_cnt_d  = win_cnt_q;
        strikes_d  = strikes_q;
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;

        // A toggle on the last live window cycle still counts as a strike.
        if (tog_r) begin
            win_cnt_d = WIN_LD;
            if (win_cnt_q == '0) begin
                strikes_d = SW'(1);
            end else if (strikes_q != STRK_MAX) begin
                strikes_d = strikes_q + 1'b1;
            end
        end else if (win_cnt_q != '0) begin
            win_cnt_d = win_cnt_q - 1'b1;
            if (win_cnt_q == WW'(1)) begin
                strikes_d = '0;
            end
        end

        unique case (state_q)
            ST_DOWN: begin
                if (link_r) begin
                    state_d    = ST_SYNC;
                    hold_cnt_d = HOLD_LD;
                end
            end
            ST_SYNC: begin
                if (!link_r) begin
                    state_d = ST_DOWN;
                end else if (hold_cnt_q == '0) begin
                    state_d = ST_UP;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            ST_UP: begin
                if (!link_r) begin
                    state_d = ST_DOWN;
                end
            end
            ST_FLAP: begin
                if (win_cnt_d == '0) begin
                    strikes_d = '0;
                    if (link_r) begin
                        state_d    = ST_SYNC;
                        hold_cnt_d = HOLD_LD;
                    end else begin
                        state_d = ST_DOWN;
                    end
                end
            end
            default: state_d = ST_DOWN;
        endcase

        flap_hit = (strikes_d == STRK_MAX);
        if (flap_hit) begin
            state_d = ST_FLAP;
        end

`ifdef LED_ACTIVITY_EN
        act_cnt_d = '0;
        if (state_d == ST_UP) begin
            if (act_cnt_q != '0) begin
                act_cnt_d = act_cnt_q - 1'b1;
            end else if (act_r) begin
                act_cnt_d = ACT_LD;
            end
        end
`endif
    end

    always_comb begin
        led_d      = 1'b0;
        flapping_d = 1'b0;
        unique case (state_d)
            ST_DOWN: led_d = 1'b0;
            ST_SYNC: led_d = slow_phase;
`ifdef LED_ACTIVITY_EN
            ST_UP:   led_d = (act_cnt_d < ACT_HALF);
`else
            ST_UP:   led_d = 1'b1;
`endif
            ST_FLAP: begin
                led_d      = fast_phase;
                flapping_d = 1'b1;
            end
            default: led_d = 1'b0;
        endcase
    end

    assign led      = led_q;
    assign flapping = flapping_q;

endmodule

// File: rtl/led_port_sequencer.sv
// Link LED sequencer: input registers, shared blink prescalers, per-port FSMs.
// Define LED_ACTIVITY_EN to add activity flicker while a port is UP.
module led_port_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned Ports      = DEF_PORTS,
    parameter int unsigned HoldOff    = DEF_HOLD_OFF,
    parameter int unsigned Cooloff    = DEF_COOLOFF,
    parameter int unsigned MaxStrikes = DEF_MAX_STRIKES,
    parameter int unsigned SlowDiv    = DEF_SLOW_DIV,
    parameter int unsigned FastDiv    = DEF_FAST_DIV,
    parameter int unsigned ActStretch = DEF_ACT_STRETCH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Ports-1:0] link_up,
    input  logic [Ports-1:0] activity,
    output logic [Ports-1:0] led,
    output logic [Ports-1:0] flapping
);

    localparam int unsigned SCW = cnt_w(SlowDiv - 1);
    localparam int unsigned FCW = cnt_w(FastDiv - 1);

    localparam logic [SCW-1:0] SLOW_TOP = SCW'(SlowDiv - 1);
    localparam logic [FCW-1:0] FAST_TOP = FCW'(FastDiv - 1);

    logic [Ports-1:0] link_r_q, link_r_d;
    logic [Ports-1:0] tog_r_q, tog_r_d;
    logic [Ports-1:0] act_r_q, act_r_d;
    logic [SCW-1:0]   slow_cnt_q, slow_cnt_d;
    logic [FCW-1:0]   fast_cnt_q, fast_cnt_d;
    logic             slow_phase_q, slow_phase_d;
    logic             fast_phase_q, fast_phase_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            link_r_q     <= '0;
            tog_r_q      <= '0;
            act_r_q      <= '0;
            slow_cnt_q   <= '0;
            fast_cnt_q   <= '0;
            slow_phase_q <= 1'b0;
            fast_phase_q <= 1'b0;
        end else begin
            link_r_q     <= link_r_d;
            tog_r_q      <= tog_r_d;
            act_r_q      <= act_r_d;
            slow_cnt_q   <= slow_cnt_d;
            fast_cnt_q   <= fast_cnt_d;
            slow_phase_q <= slow_phase_d;
            fast_phase_q <= fast_phase_d;
        end
    end

    always_comb begin
        link_r_d = link_up;
        tog_r_d  = link_up ^ link_r_q;
        act_r_d  = activity;

        slow_cnt_d   = slow_cnt_q + 1'b1;
        slow_phase_d = slow_phase_q;
        if (slow_cnt_q == SLOW_TOP) begin
            slow_cnt_d   = '0;
            slow_phase_d = ~slow_phase_q;
        end

        fast_cnt_d   = fast_cnt_q + 1'b1;
        fast_phase_d = fast_phase_q;
        if (fast_cnt_q == FAST_TOP) begin
            fast_cnt_d   = '0;
            fast_phase_d = ~fast_phase_q;
        end
    end

    // Ports see the phase that will be live after this edge, so every
    // registered LED lines up with the prescaler phase of the same cycle.
    for (genvar i = 0; i < Ports; i++) begin : g_port
        led_port_fsm #(
            .HoldOff   (HoldOff),
            .Cooloff   (Cooloff),
            .MaxStrikes(MaxStrikes),
            .ActStretch(ActStretch)
        ) u_fsm (
            .clk       (clk),
            .reset     (reset),
            .link_r    (link_r_q[i]),
            .tog_r     (tog_r_q[i]),
            .act_r     (act_r_q[i]),
            .slow_phase(slow_phase_d),
            .fast_phase(fast_phase_d),
            .led       (led[i]),
            .flapping  (flapping[i])
        );
    end

endmodule

// File: tb/tb_led_port_sequencer.sv
// Scoreboard bench for led_port_sequencer against a cycle-level reference model.
// Build with or without LED_ACTIVITY_EN; the model follows the same macro.
module tb_led_port_sequencer;

    localparam int P    = 2;
    localparam int HOLD = 4;
    localparam int COOL = 8;
    localparam int MAXS = 3;
    localparam int SDIV = 8;
    localparam int FDIV = 2;
    localparam int ACTS = 3;

    localparam int S_DOWN = 0;
    localparam int S_SYNC = 1;
    localparam int S_UP   = 2;
    localparam int S_FLAP = 3;

    typedef struct {
        logic [P-1:0] led;
        logic [P-1:0] flap;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [P-1:0] link_up;
    logic [P-1:0] activity;
    logic [P-1:0] led;
    logic [P-1:0] flapping;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: ages instead of down-counters, flicker as a position.
    int m_state[P];
    int m_sync[P];
    int m_age[P];
    int m_str[P];
    int m_pos[P];
    bit m_link[P];
    bit m_tog[P];
    bit m_actr[P];
    int m_n;

    led_port_sequencer #(
        .Ports     (P),
        .HoldOff   (HOLD),
        .Cooloff   (COOL),
        .MaxStrikes(MAXS),
        .SlowDiv   (SDIV),
        .FastDiv   (FDIV),
        .ActStretch(ACTS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .link_up (link_up),
        .activity(activity),
        .led     (led),
        .flapping(flapping)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input bit rst, input logic [P-1:0] lk,
                              input logic [P-1:0] ac,
                              output logic [P-1:0] e_led,
                              output logic [P-1:0] e_flap);
        bit sp;
        bit fp;
        e_led  = '0;
        e_flap = '0;
        if (rst) begin
            m_n = 0;
            for (int p = 0; p < P; p++) begin
                m_state[p] = S_DOWN;
                m_sync[p]  = 0;
                m_age[p]   = COOL;
                m_str[p]   = 0;
                m_pos[p]   = -1;
                m_link[p]  = 0;
                m_tog[p]   = 0;
                m_actr[p]  = 0;
            end
            return;
        end
        m_n++;
        sp = ((m_n / SDIV) % 2) == 1;
        fp = ((m_n / FDIV) % 2) == 1;
        for (int p = 0; p < P; p++) begin
            bit lr;
            bit ar;
            int nst;
            lr = m_link[p];
            ar = m_actr[p];
            if (m_tog[p]) begin
                if (m_age[p] >= COOL) m_str[p] = 1;
                else m_str[p] = (m_str[p] + 1 > MAXS) ? MAXS : m_str[p] + 1;
                m_age[p] = 0;
            end else if (m_age[p] < COOL) begin
                m_age[p]++;
                if (m_age[p] == COOL) m_str[p] = 0;
            end
            nst = m_state[p];
            case (m_state[p])
                S_DOWN: if (lr) begin nst = S_SYNC; m_sync[p] = 0; end
                S_SYNC: begin
                    if (!lr) nst = S_DOWN;
                    else if (m_sync[p] == HOLD) nst = S_UP;
                    else m_sync[p]++;
                end
                S_UP: if (!lr) nst = S_DOWN;
                default: begin
                    if (m_age[p] == COOL) begin
                        nst = lr ? S_SYNC : S_DOWN;
                        m_sync[p] = 0;
                        m_str[p] = 0;
                    end
                end
            endcase
            if (m_str[p] == MAXS) nst = S_FLAP;
            if (nst != S_UP) m_pos[p] = -1;
            else if (m_pos[p] < 0 || m_pos[p] == 2 * ACTS - 1) m_pos[p] = ar ? 0 : -1;
            else m_pos[p]++;
            m_state[p] = nst;
            case (nst)
                S_SYNC: e_led[p] = sp;
`ifdef LED_ACTIVITY_EN
                S_UP:   e_led[p] = !(m_pos[p] >= 0 && m_pos[p] < ACTS);
`else
                S_UP:   e_led[p] = 1'b1;
`endif
                S_FLAP: begin e_led[p] = fp; e_flap[p] = 1'b1; end
                default: e_led[p] = 1'b0;
            endcase
            m_tog[p]  = (lk[p] != lr);
            m_link[p] = lk[p];
            m_actr[p] = ac[p];
        end
    endtask

    task automatic step(input bit rst, input logic [P-1:0] lk,
                        input logic [P-1:0] ac);
        exp_t e;
        reset    = rst;
        link_up  = lk;
        activity = ac;
        model_edge(rst, lk, ac, e.led, e.flap);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic [P-1:0] lk,
                       input logic [P-1:0] ac);
        for (int i = 0; i < n; i++) step(1'b0, lk, ac);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (led !== e.led) begin
                    n_bad++;
                    $display("FAIL led t=%0t got=%b exp=%b", $time, led, e.led);
                end
                n_cmp++;
                if (flapping !== e.flap) begin
                    n_bad++;
                    $display("FAIL flapping t=%0t got=%b exp=%b",
                             $time, flapping, e.flap);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [P-1:0] lk;
        logic [P-1:0] ac;
        int pct;
        step(1'b1, 2'b00, 2'b00);
        step(1'b1, 2'b00, 2'b00);
        // link up on port 0: slow blink in SYNC, then solid
        run(14, 2'b01, 2'b00);
        // link drop from UP
        run(4, 2'b00, 2'b00);
        run(10, 2'b00, 2'b00);
        // three toggles 3 apart -> flap, then quiet high -> SYNC -> UP
        run(3, 2'b01, 2'b00);
        run(3, 2'b00, 2'b00);
        run(20, 2'b01, 2'b00);
        run(12, 2'b00, 2'b00);
        // toggles 9 apart: window has closed, no flap
        run(9, 2'b01, 2'b00);
        run(12, 2'b00, 2'b00);
        // toggles 8 apart: last window cycle still counts
        run(8, 2'b01, 2'b00);
        run(8, 2'b00, 2'b00);
        run(16, 2'b01, 2'b00);
        run(12, 2'b00, 2'b00);
        // continuous activity while UP
        run(10, 2'b11, 2'b11);
        run(18, 2'b11, 2'b11);
        run(12, 2'b00, 2'b00);
        // flap on both ports, then reset while flapping
        run(3, 2'b11, 2'b00);
        run(3, 2'b00, 2'b00);
        run(5, 2'b11, 2'b00);
        step(1'b1, 2'b11, 2'b00);
        run(12, 2'b11, 2'b00);
        // randomized traffic at several toggle rates
        lk = 2'b00;
        for (int blk = 0; blk < 3; blk++) begin
            pct = (blk == 0) ? 3 : ((blk == 1) ? 15 : 40);
            for (int c = 0; c < 250; c++) begin
                for (int p = 0; p < P; p++) begin
                    if ($urandom_range(0, 99) < pct) lk[p] = ~lk[p];
                end
                ac = P'($urandom_range(0, 3));
                step($urandom_range(0, 199) == 0, lk, ac);
            end
        end
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
